vend_dispense_scheduler: RTL and testbench
==========================================

# vend_dispense_scheduler

Sequences one vend transaction after the controller has collected credit and a product selection: checks stock, drives the product dispense output, then pays out change coin by coin. Sits between the vending machine controller and the physical outputs. It is paced by the 1 Hz clock-enable pulse on the system `clk` domain, and exposes remaining change for the seven-segment display.

## Interface
- `INV_INIT`, 5: per-product stock loaded at reset/restock (0..7)
- `DISP_TICKS`, 2: ticks the dispense output is held
- `clk`  in  1  system clock
- `clr`  in  1  synchronous, active-high reset
- `tick`  in  1  1 Hz clock-enable pulse, one `clk` wide
- `restock`  in  1  reload all stock to `INV_INIT`
- `req_valid`  in  1  vend request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_prod`  in  2  product index; prices 0:15c, 1:20c, 2:25c, 3:30c
- `req_credit`  in  8  inserted credit, binary cents, multiple of 5
- `dispense`  out  4  one-hot product output (bit 0 = 15c product)
- `coin_out`  out  3  one-cycle coin pulse: [2]=25c, [1]=10c, [0]=5c
- `change_left`  out  8  change still owed, binary cents
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle completion pulse
- `status`  out  2  valid with `done`: 0 OK, 1 sold out, 2 insufficient credit
- `stock`  out  12  3 bits per product, product 0 in [2:0]

## Operation
- States: IDLE, CHECK, DISPENSE, CHANGE, DONE.
- IDLE:
  - `req_ready = !restock`.
  - On accept, latch `req_prod` and `req_credit`, then go to CHECK.
  - `restock` in IDLE loads all counts to `INV_INIT`. It is ignored in every other state.
- CHECK (exactly one `clk`):
  - Stock 0: `status`=1, `change_left`=credit, go to CHANGE.
  - Credit < price: `status`=2, `change_left`=credit, go to CHANGE.
  - Otherwise: `status`=0, `change_left`=credit−price, decrement that product's stock, go to DISPENSE.
- DISPENSE:
  - `dispense[prod]` is held high.
  - Count `tick` pulses; after `DISP_TICKS` ticks, drop `dispense` and go to CHANGE.
- CHANGE:
  - If `change_left`=0 on entry or at any cycle, go to DONE without waiting for a tick.
  - On each `tick`, pulse the largest coin ≤ `change_left` (25, else 10, else 5) and subtract its value in the same cycle.
  - A 5c remainder is the minimum; credit is always a multiple of 5.
- DONE: `done`=1 for one `clk`, `status` valid, then go to IDLE.
- `busy` = state ≠ IDLE.
- Arithmetic is 8-bit unsigned. The subtraction never underflows because the selector only picks coins ≤ `change_left`.
- Stock saturates at 0; CHECK guarantees no decrement happens at 0.

## Timing
- Reset values: state IDLE, all stock = `INV_INIT`. `dispense`, `coin_out`, `change_left`, `busy`, `done`, `status` are all 0. `req_ready`=1.
- `clr` asserted mid-transaction aborts it on the next edge. No coin or done pulse is emitted. Owed change is discarded; the controller owns refund after reset.
- Accept → CHECK: 1 cycle. CHECK → DISPENSE or CHANGE: 1 cycle.
- DISPENSE width: from the CHECK exit edge through the `DISP_TICKS`-th tick edge.
- A `tick` in the same cycle as the DISPENSE→CHANGE transition is not used for a coin. The first coin uses the next tick.
- `coin_out` rises only in the cycle of a `tick` and is registered, so it appears one `clk` after the tick edge.
- `change_left` updates in the same registered cycle as the coin pulse.
- `req_valid` is ignored while `busy`. It is not queued.

## Structure
- Package `vend_pkg`:
  - price table (15/20/25/30)
  - coin values and the `coin_out` bit map
  - state enum
  - status codes
- Sub-module `vend_inventory`:
  - four 3-bit counters
  - restock load
  - decrement strobe with product index
  - packed `stock` output
- Coin selection is a small combinational function in the scheduler.

## Test plan
- Reset, then request prod 1 with credit 30:
  - `dispense`=0010 for 2 ticks.
  - Then one 10c pulse, `change_left` goes 10→0.
  - `done` with `status`=0, stock[5:3]=4.
- Prod 3, credit 100:
  - Change 70 paid as 25, 25, 10, 10 on four consecutive ticks.
  - `done`, `status`=0.
- Prod 0, credit 10:
  - No dispense; one 10c pulse; `status`=2.
  - Stock unchanged at 5.
- Five vends of prod 2 at 25c exact, then a sixth request with credit 25:
  - Sixth gives no dispense, a 25c refund, and `status`=1.
  - Assert `restock` with `req_valid` in IDLE: `req_ready`=0 that cycle, stock[8:6]=5, and the request is accepted the next cycle.
- `clr` pulsed during CHANGE with 45c owed:
  - Next cycle: IDLE, all outputs 0, no further `coin_out`, stock back to 5.
- Exact credit 20 on prod 1:
  - CHANGE exits to DONE immediately, within one cycle of DISPENSE end.
  - Zero coin pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, prices and coin encoding for the vend dispense scheduler
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE,
    ST_DONE
  } state_t;

  localparam logic [1:0] STATUS_OK        = 2'd0;
  localparam logic [1:0] STATUS_SOLD_OUT  = 2'd1;
  localparam logic [1:0] STATUS_NO_CREDIT = 2'd2;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] COIN_25   = 3'b100;

  function automatic logic [7:0] price(input logic [1:0] prod);
    price = 8'd15;
    case (prod)
      2'd0: price = 8'd15;
      2'd1: price = 8'd20;
      2'd2: price = 8'd25;
      2'd3: price = 8'd30;
      default: price = 8'd15;
    endcase
  endfunction

  function automatic logic [7:0] coin_value(input logic [2:0] coin);
    coin_value = 8'd0;
    case (coin)
      COIN_25: coin_value = 8'd25;
      COIN_10: coin_value = 8'd10;
      COIN_5:  coin_value = 8'd5;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// rtl/vend_inventory.sv - four 3-bit per-product stock counters with restock load and decrement
module vend_inventory #(
  parameter int INV_INIT = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_load,
  input  logic        i_dec,
  input  logic [1:0]  i_prod,
  output logic [11:0] o_stock
);

  localparam logic [2:0] LP_INIT = 3'(INV_INIT);

  logic [2:0] r_cnt [4];

  always_ff @(posedge clk) begin
    if (clr || i_load) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= LP_INIT;
    end else if (i_dec && (r_cnt[i_prod] != 3'd0)) begin
      r_cnt[i_prod] <= r_cnt[i_prod] - 3'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign o_stock[3*g +: 3] = r_cnt[g];
  end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// rtl/vend_dispense_scheduler.sv - sequences stock check, product dispense and tick-paced change payout
module vend_dispense_scheduler
  import vend_pkg::*;
#(
  parameter int INV_INIT   = 5,
  parameter int DISP_TICKS = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        tick,
  input  logic        restock,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_prod,
  input  logic [7:0]  req_credit,
  output logic [3:0]  dispense,
  output logic [2:0]  coin_out,
  output logic [7:0]  change_left,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [11:0] stock
);

  localparam logic [7:0] LP_LAST_TICK = 8'(DISP_TICKS - 1);

  state_t     r_state, w_next;
  logic [1:0] r_prod;
  logic [7:0] r_credit;
  logic [7:0] r_change;
  logic [1:0] r_status;
  logic [2:0] r_coin;
  logic [7:0] r_tick_cnt;
  logic [2:0] w_stock_cur;
  logic [2:0] w_coin;
  logic       w_dec;
  logic       w_load;
  logic       w_reject;

  function automatic logic [2:0] f_coin(input logic [7:0] owed);
    if (owed >= 8'd25)      f_coin = COIN_25;
    else if (owed >= 8'd10) f_coin = COIN_10;
    else if (owed != 8'd0)  f_coin = COIN_5;
    else                    f_coin = COIN_NONE;
  endfunction

  vend_inventory #(.INV_INIT(INV_INIT)) u_inventory (
    .clk     (clk),
    .clr     (clr),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .i_prod  (r_prod),
    .o_stock (stock)
  );

  always_comb begin
    w_stock_cur = stock[2:0];
    case (r_prod)
      2'd0: w_stock_cur = stock[2:0];
      2'd1: w_stock_cur = stock[5:3];
      2'd2: w_stock_cur = stock[8:6];
      2'd3: w_stock_cur = stock[11:9];
      default: w_stock_cur = stock[2:0];
    endcase
  end

  assign w_reject = (w_stock_cur == 3'd0) || (r_credit < price(r_prod));
  assign w_coin   = f_coin(r_change);

  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_dec  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (restock)        w_load = 1'b1;
        else if (req_valid) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_reject) begin
          w_next = ST_CHANGE;
        end else begin
          w_next = ST_DISPENSE;
          w_dec  = 1'b1;
        end
      end
      ST_DISPENSE: if (tick && (r_tick_cnt == LP_LAST_TICK)) w_next = ST_CHANGE;
      ST_CHANGE:   if (r_change == 8'd0) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Coin and remaining change update together so the display never shows a paid coin as owed.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prod     <= 2'd0;
      r_credit   <= 8'd0;
      r_change   <= 8'd0;
      r_status   <= STATUS_OK;
      r_coin     <= COIN_NONE;
      r_tick_cnt <= 8'd0;
    end else begin
      r_coin <= COIN_NONE;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_prod   <= req_prod;
            r_credit <= req_credit;
          end
        end
        ST_CHECK: begin
          r_tick_cnt <= 8'd0;
          if (w_stock_cur == 3'd0) begin
            r_status <= STATUS_SOLD_OUT;
            r_change <= r_credit;
          end else if (r_credit < price(r_prod)) begin
            r_status <= STATUS_NO_CREDIT;
            r_change <= r_credit;
          end else begin
            r_status <= STATUS_OK;
            r_change <= r_credit - price(r_prod);
          end
        end
        ST_DISPENSE: if (tick) r_tick_cnt <= r_tick_cnt + 8'd1;
        ST_CHANGE: begin
          if (tick && (r_change != 8'd0)) begin
            r_coin   <= w_coin;
            r_change <= r_change - coin_value(w_coin);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE) && !restock;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign dispense    = (r_state == ST_DISPENSE) ? (4'b0001 << r_prod) : 4'b0000;
  assign coin_out    = r_coin;
  assign change_left = r_change;
  assign status      = r_status;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// tb/tb_vend_dispense_scheduler.sv - self-checking bench for vend_dispense_scheduler
module tb_vend_dispense_scheduler;

  localparam int INV_INIT   = 5;
  localparam int DISP_TICKS = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        tick;
  logic        restock;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_prod;
  logic [7:0]  req_credit;
  logic [3:0]  dispense;
  logic [2:0]  coin_out;
  logic [7:0]  change_left;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [11:0] stock;

  int total = 0;
  int bad   = 0;
  int m_stock [4];

  always #5 clk = ~clk;

  vend_dispense_scheduler #(.INV_INIT(INV_INIT), .DISP_TICKS(DISP_TICKS)) dut (
    .clk         (clk),
    .clr         (clr),
    .tick        (tick),
    .restock     (restock),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_prod    (req_prod),
    .req_credit  (req_credit),
    .dispense    (dispense),
    .coin_out    (coin_out),
    .change_left (change_left),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .stock       (stock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_stock();
    logic [11:0] s;
    s = 12'd0;
    for (int i = 0; i < 4; i++) s = s | (12'(m_stock[i] & 7) << (3*i));
    return s;
  endfunction

  function automatic int tb_coin_val(input logic [2:0] c);
    if (c == 3'b100) return 25;
    if (c == 3'b010) return 10;
    if (c == 3'b001) return 5;
    return 999;
  endfunction

  task automatic model_restock();
    for (int i = 0; i < 4; i++) m_stock[i] = INV_INIT;
  endtask

  task automatic vend(input int p, input int c);
    int price, st, rem, t;
    int exp_coins[$];
    int exp_rem[$];
    int disp_ticks, bad_disp, coin_bad, untimed, ncoins, prev_tick;
    int seen_done, disp_seen, disp_end, done_cyc, st_obs, early_coin;
    disp_ticks = 0; bad_disp = 0; coin_bad = 0; untimed = 0; ncoins = 0;
    seen_done = 0; disp_seen = 0; disp_end = -1; done_cyc = -1; st_obs = -1; early_coin = 0;
    price = 15 + 5 * p;
    if (m_stock[p] == 0)  st = 1;
    else if (c < price)   st = 2;
    else                  st = 0;
    rem = (st == 0) ? c - price : c;
    if (st == 0) m_stock[p]--;
    while (rem > 0) begin
      t = (rem >= 25) ? 25 : ((rem >= 10) ? 10 : 5);
      rem -= t;
      exp_coins.push_back(t);
      exp_rem.push_back(rem);
    end
    req_valid  = 1'b1;
    req_prod   = 2'(p);
    req_credit = 8'(c);
    tick       = 1'($urandom_range(0, 1));
    prev_tick  = int'(tick);
    step();
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && seen_done == 0; cyc++) begin
      if (coin_out != 3'b000) begin
        if (prev_tick == 0) untimed++;
        if (ncoins >= exp_coins.size()) coin_bad++;
        else if (tb_coin_val(coin_out) != exp_coins[ncoins] || int'(change_left) != exp_rem[ncoins]) coin_bad++;
        ncoins++;
      end
      if (dispense != 4'b0000) begin
        disp_seen = 1;
        if (dispense != 4'(1 << p)) bad_disp++;
      end else if (disp_seen != 0 && disp_end < 0) begin
        disp_end = cyc;
        if (coin_out != 3'b000) early_coin++;
      end
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        st_obs    = int'(status);
      end else begin
        tick = 1'($urandom_range(0, 1));
        if (dispense != 4'b0000 && tick) disp_ticks++;
        prev_tick = int'(tick);
        step();
      end
    end
    tick = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("status", st_obs, st);
    chk("dispense_ticks", disp_ticks, (st == 0) ? DISP_TICKS : 0);
    chk("dispense_onehot", bad_disp, 0);
    chk("coin_count", ncoins, exp_coins.size());
    chk("coin_sequence", coin_bad, 0);
    chk("coin_without_tick", untimed, 0);
    chk("coin_on_dispense_exit", early_coin, 0);
    chk("stock_after", stock, model_stock());
    if (st == 0 && exp_coins.size() == 0) chk("zero_change_gap", done_cyc - disp_end, 1);
    step();
    chk("back_idle_ready", req_ready, 1);
    chk("back_idle_busy", busy, 0);
  endtask

  initial begin
    int found, dseen, ncoin_after;
    clr = 1'b1; tick = 1'b0; restock = 1'b0; req_valid = 1'b0;
    req_prod = 2'd0; req_credit = 8'd0;
    model_restock();
    step(); step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_coin", coin_out, 0);
    chk("rst_change", change_left, 0);
    chk("rst_status", status, 0);
    chk("rst_stock", stock, model_stock());
    clr = 1'b0;
    step();

    vend(1, 30);
    chk("p1_stock_field", stock[5:3], 4);
    vend(3, 100);
    vend(0, 10);
    chk("p0_stock_field", stock[2:0], 5);
    for (int k = 0; k < 6; k++) vend(2, 25);

    restock = 1'b1; req_valid = 1'b1; req_prod = 2'd2; req_credit = 8'd25;
    #1;
    chk("restock_ready_low", req_ready, 0);
    step();
    model_restock();
    chk("restock_field", stock[8:6], 5);
    chk("restock_not_accepted", busy, 0);
    restock = 1'b0;
    #1;
    chk("restock_ready_back", req_ready, 1);
    vend(2, 25);

    req_valid = 1'b1; req_prod = 2'd0; req_credit = 8'd60; tick = 1'b0;
    step();
    req_valid = 1'b0;
    found = 0; dseen = 0;
    for (int cyc = 0; cyc < 300 && found == 0; cyc++) begin
      if (dispense != 4'b0000) dseen = 1;
      else if (dseen != 0 && busy) found = 1;
      if (found == 0) begin
        tick = 1'($urandom_range(0, 1));
        step();
      end
    end
    chk("clr_reached_change", found, 1);
    chk("clr_owed", change_left, 45);
    tick = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; tick = 1'b0;
    model_restock();
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_coin", coin_out, 0);
    chk("clr_change", change_left, 0);
    chk("clr_dispense", dispense, 0);
    chk("clr_status", status, 0);
    chk("clr_ready", req_ready, 1);
    chk("clr_stock", stock, model_stock());
    ncoin_after = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick = 1'b1;
      step();
      if (coin_out != 3'b000 || done) ncoin_after++;
    end
    tick = 1'b0;
    chk("clr_no_more_coins", ncoin_after, 0);

    vend(1, 20);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        restock = 1'b1;
        step();
        restock = 1'b0;
        model_restock();
        chk("rand_restock_stock", stock, model_stock());
      end
      vend(int'($urandom_range(0, 3)), 5 * int'($urandom_range(0, 24)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
